// File: rtl/freq_gen_if.sv
// Request/status bundle between a stimulus harness (master) and freq_gen (slave).
interface freq_gen_if;
  logic [15:0] bcd_in;
  logic        load;
  logic        busy;
  logic        err;
  logic        active;
  logic        signal_f;
  logic        signal_t;

  modport master (output bcd_in, load, input busy, err, active, signal_f, signal_t);
  modport slave  (input bcd_in, load, output busy, err, active, signal_f, signal_t);
endinterface

// File: rtl/freq_gen.sv
// Programmable square-wave generator: BCD Hz setting -> half-period count, plus a 1 Hz reference.
// Optional FREQ_GEN_PHASE_RST_EN: a valid setting restarts signal_f with a fresh low phase.
module freq_gen #(
  parameter int CLK_HZ = 16000000,
  parameter int DIV_W  = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  freq_gen_if.slave   bus
);
  localparam int RMW = (DIV_W > 14) ? DIV_W : 14;
  localparam int CW  = $clog2(DIV_W + 1);
  localparam logic [DIV_W-1:0] HALF_CLK = DIV_W'(CLK_HZ / 2);

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_CHECK, S_DIV, S_APPLY} state_t;

  state_t           r_state, w_state_nxt;
  logic [15:0]      r_bcd;
  logic [13:0]      r_bin;
  logic             r_bad;
  logic [CW-1:0]    r_step;
  logic [DIV_W-1:0] r_dvd, r_quo;
  logic [RMW-1:0]   r_rem;
  logic             r_busy, r_err, r_active;
  logic [DIV_W-1:0] r_half, r_pend, r_cnt_f, r_cnt_t;
  logic             r_pend_vld, r_sig_f, r_sig_t;

  logic             w_accept, w_reject, w_take, w_wrap, w_sub_ok;
  logic [3:0]       w_digit;
  logic [13:0]      w_bin_nxt;
  logic [RMW:0]     w_trial;

  assign w_digit   = r_bcd[15:12];
  assign w_bin_nxt = r_bin * 14'd10 + {10'd0, w_digit};
  assign w_trial   = {r_rem, r_dvd[DIV_W-1]};
  assign w_sub_ok  = (w_trial >= (RMW+1)'(r_bin));
  assign w_wrap    = r_active && (r_cnt_f == r_half - DIV_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.load && !r_busy) begin
                 w_accept    = 1'b1;
                 w_state_nxt = S_CONV;
               end
      S_CONV:  if (r_step == CW'(3)) w_state_nxt = S_CHECK;
      S_CHECK: if (r_bad || r_bin == 14'd0) begin
                 w_reject    = 1'b1;
                 w_state_nxt = S_IDLE;
               end else begin
                 w_state_nxt = S_DIV;
               end
      S_DIV:   if (r_step == CW'(DIV_W - 1)) w_state_nxt = S_APPLY;
      S_APPLY: begin
                 w_state_nxt = S_IDLE;
                 if (r_quo == '0) w_reject = 1'b1;
                 else             w_take   = 1'b1;
               end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_bcd    <= '0;
      r_bin    <= '0;
      r_bad    <= 1'b0;
      r_step   <= '0;
      r_dvd    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // busy drops one cycle after the FSM is back in IDLE
      if (w_accept)                r_busy <= 1'b1;
      else if (r_state == S_IDLE)  r_busy <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
                  r_bcd  <= bus.bcd_in;
                  r_bin  <= '0;
                  r_bad  <= 1'b0;
                  r_step <= '0;
                end
        S_CONV: begin
                  r_bin  <= w_bin_nxt;
                  r_bad  <= r_bad | (w_digit > 4'd9);
                  r_bcd  <= {r_bcd[11:0], 4'h0};
                  r_step <= (r_step == CW'(3)) ? '0 : r_step + CW'(1);
                end
        S_CHECK: begin
                  r_dvd  <= HALF_CLK;
                  r_rem  <= '0;
                  r_quo  <= '0;
                  r_step <= '0;
                end
        S_DIV:  begin
                  r_dvd  <= {r_dvd[DIV_W-2:0], 1'b0};
                  r_rem  <= RMW'(w_sub_ok ? w_trial - (RMW+1)'(r_bin) : w_trial);
                  r_quo  <= {r_quo[DIV_W-2:0], w_sub_ok};
                  r_step <= r_step + CW'(1);
                end
        default: ;
      endcase
      if (w_reject)    r_err <= 1'b1;
      else if (w_take) r_err <= 1'b0;
      if (w_take) r_active <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_half     <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_cnt_f    <= '0;
      r_sig_f    <= 1'b0;
    end else begin
`ifdef FREQ_GEN_PHASE_RST_EN
      if (w_take) begin
        r_half     <= r_quo;
        r_pend_vld <= 1'b0;
        r_cnt_f    <= '0;
        r_sig_f    <= 1'b0;
      end
`else
      if (w_take && !r_active) begin
        r_half  <= r_quo;
        r_cnt_f <= '0;
      end
`endif
      else if (w_wrap) begin
        r_cnt_f <= '0;
        r_sig_f <= ~r_sig_f;
        if (r_pend_vld) begin
          r_half     <= r_pend;
          r_pend_vld <= 1'b0;
        end
      end else if (r_active) begin
        r_cnt_f <= r_cnt_f + DIV_W'(1);
      end
`ifndef FREQ_GEN_PHASE_RST_EN
      // a new setting waits for the next wrap so no runt pulse is emitted
      if (w_take && r_active) begin
        r_pend     <= r_quo;
        r_pend_vld <= 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_t <= '0;
      r_sig_t <= 1'b0;
    end else if (r_cnt_t == HALF_CLK - DIV_W'(1)) begin
      r_cnt_t <= '0;
      r_sig_t <= ~r_sig_t;
    end else begin
      r_cnt_t <= r_cnt_t + DIV_W'(1);
    end
  end

  assign bus.busy     = r_busy;
  assign bus.err      = r_err;
  assign bus.active   = r_active;
  assign bus.signal_f = r_sig_f;
  assign bus.signal_t = r_sig_t;
endmodule

// File: tb/tb_freq_gen.sv
// Scoreboard bench for freq_gen at CLK_HZ=1000, DIV_W=12 (half-clock count 500).
module tb_freq_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  freq_gen_if bus ();

  freq_gen #(.CLK_HZ(1000), .DIV_W(12)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic        active;
    logic [31:0] len;
  } res_t;

  res_t        exp_q[$];
  int unsigned tog_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned mcyc = 0, rise_cyc = 0, last_tog = 0;
  int          tog_cnt = 0;
  logic        p_busy = 1'b0, p_sf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitor: completions pop err/active/busy-length; signal_f edges pop intervals.
  always @(posedge clk) begin
    res_t r;
    #1;
    mcyc++;
    if (!rst_n) begin
      p_busy   = 1'b0;
      p_sf     = 1'b0;
      last_tog = mcyc;
    end else begin
      if (bus.busy && !p_busy) rise_cyc = mcyc;
      if (!bus.busy && p_busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: busy fell with nothing expected");
        end else begin
          r = exp_q.pop_front();
          chk("busy_len", mcyc - rise_cyc, r.len);
          chk("err", {31'd0, bus.err}, {31'd0, r.err});
          chk("active", {31'd0, bus.active}, {31'd0, r.active});
        end
      end
      if (bus.signal_f != p_sf) begin
        tog_cnt++;
        if (tog_q.size() != 0) chk("f_interval", mcyc - last_tog, tog_q.pop_front());
        last_tog = mcyc;
      end
      p_busy = bus.busy;
      p_sf   = bus.signal_f;
    end
  end

  task automatic do_load(input logic [15:0] v, input logic e, input logic a, input int unsigned len);
    res_t r;
    r.err = e; r.active = a; r.len = len;
    @(negedge clk);
    bus.bcd_in = v;
    bus.load   = 1'b1;
    exp_q.push_back(r);
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      timeout("wait_done");
      exp_q.delete();
    end
  endtask

  task automatic skip_tog(input int k);
    int start = tog_cnt;
    int n = 0;
    while (tog_cnt - start < k && n < 300 * k) begin
      @(negedge clk);
      n++;
    end
    if (tog_cnt - start < k) timeout("skip_toggle");
  endtask

  task automatic expect_tog(input int unsigned iv, input int cnt);
    int n = 0;
    for (int i = 0; i < cnt; i++) tog_q.push_back(iv);
    while (tog_q.size() != 0 && n < int'(iv) * cnt + 50) begin
      @(negedge clk);
      n++;
    end
    if (tog_q.size() != 0) begin
      timeout("f_toggles");
      tog_q.delete();
    end
  endtask

  initial begin
    int n;
    bus.bcd_in = 16'h0000;
    bus.load   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_active", {31'd0, bus.active}, 32'd0);
    chk("rst_signal_f", {31'd0, bus.signal_f}, 32'd0);
    chk("rst_signal_t", {31'd0, bus.signal_t}, 32'd0);
    rst_n = 1'b1;

    // 5 Hz: half = 500/5 = 100
    do_load(16'h0005, 1'b0, 1'b1, 19);
    wait_idle();
    skip_tog(2);
    expect_tog(100, 3);

    // 10 Hz: half = 50
    do_load(16'h0010, 1'b0, 1'b1, 19);
    wait_idle();
`ifdef FREQ_GEN_PHASE_RST_EN
    chk("phase_rst_low", {31'd0, bus.signal_f}, 32'd0);
`endif
    skip_tog(2);
    expect_tog(50, 3);

    // invalid digit: rejected after 6 cycles, waveform unchanged
    do_load(16'h00A3, 1'b1, 1'b1, 6);
    wait_idle();
    skip_tog(1);
    expect_tog(50, 2);

    // zero setting, then a valid load clears err
    do_load(16'h0000, 1'b1, 1'b1, 6);
    wait_idle();
    do_load(16'h0010, 1'b0, 1'b1, 19);
    wait_idle();
    skip_tog(2);
    expect_tog(50, 2);

    // 501 Hz: 500/501 = 0 -> rejected at the end of division
    do_load(16'h0501, 1'b1, 1'b1, 19);
    wait_idle();
    skip_tog(1);
    expect_tog(50, 1);

    // 500 Hz: half = 1, toggle every cycle
    do_load(16'h0500, 1'b0, 1'b1, 19);
    wait_idle();
    skip_tog(2);
    expect_tog(1, 4);

    // second pulse while busy must be ignored
    do_load(16'h0005, 1'b0, 1'b1, 19);
    repeat (2) @(negedge clk);
    bus.bcd_in = 16'h0010;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
    wait_idle();
    skip_tog(2);
    expect_tog(100, 2);

    // async reset in the middle of the division
    @(negedge clk);
    bus.bcd_in = 16'h0010;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy_before_rst", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_err", {31'd0, bus.err}, 32'd0);
    chk("arst_active", {31'd0, bus.active}, 32'd0);
    chk("arst_signal_f", {31'd0, bus.signal_f}, 32'd0);
    chk("arst_signal_t", {31'd0, bus.signal_t}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.signal_t) break;
    end
    chk("t_first_rise", n, 32'd500);
    chk("active_after_rst", {31'd0, bus.active}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
